// File: rtl/bp_pkg.sv
// bp_pkg: shared 2-bit saturating counter type, encodings and update function for the branch predictor.
package bp_pkg;
  typedef logic [1:0] ctr_t;
  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;
  function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
    return taken ? ((ctr == CTR_ST) ? ctr : ctr + 2'd1)
                 : ((ctr == CTR_SNT) ? ctr : ctr - 2'd1);
  endfunction
endpackage

// File: rtl/bp_counter_table.sv
// bp_counter_table: 2^INDEX_BITS x 2-bit BHT with one async read port and one sync saturating-update port.
// The write port carries the branch outcome; the read-modify-write happens here so the table needs only one read port.
module bp_counter_table
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_BITS-1:0] rd_idx_i,
  output ctr_t                  rd_ctr_o,
  input  logic                  wr_en_i,
  input  logic [INDEX_BITS-1:0] wr_idx_i,
  input  logic                  wr_taken_i
);
  ctr_t table_q [2**INDEX_BITS];
  assign rd_ctr_o = table_q[rd_idx_i];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < 2**INDEX_BITS; i++) table_q[i] <= CTR_WNT;
    else if (wr_en_i)
      table_q[wr_idx_i] <= ctr_next(table_q[wr_idx_i], wr_taken_i);
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit saturating-counter BHT with combinational lookup and execute-stage mispredict flag.
// Optional BP_STATS_EN adds wrapping 32-bit branch and mispredict counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int PC_WIDTH   = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PC_WIDTH-1:0] fetch_pc,
  input  logic                fetch_branch,
  output logic                prediction,
  input  logic                update_valid,
  input  logic [PC_WIDTH-1:0] update_pc,
  input  logic                update_taken,
  input  logic                update_prediction,
  output logic                mispredict
`ifdef BP_STATS_EN
  ,
  output logic [31:0]         stat_branches,
  output logic [31:0]         stat_mispredicts
`endif
);
  logic [INDEX_BITS-1:0] fetch_idx, update_idx;
  ctr_t                  fetch_ctr;
  logic                  unused;
  assign fetch_idx  = fetch_pc[INDEX_BITS+1:2];
  assign update_idx = update_pc[INDEX_BITS+1:2];
  // Upper PC bits alias by design; only the index field matters.
  assign unused = ^{fetch_pc[PC_WIDTH-1:INDEX_BITS+2], fetch_pc[1:0],
                    update_pc[PC_WIDTH-1:INDEX_BITS+2], update_pc[1:0]};
  bp_counter_table #(.INDEX_BITS(INDEX_BITS)) u_table (
    .clk       (clk),
    .rst_n     (reset),
    .rd_idx_i  (fetch_idx),
    .rd_ctr_o  (fetch_ctr),
    .wr_en_i   (update_valid),
    .wr_idx_i  (update_idx),
    .wr_taken_i(update_taken)
  );
  assign prediction = fetch_branch & fetch_ctr[1];
  assign mispredict = update_valid & (update_taken != update_prediction);
`ifdef BP_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d, stat_mispredicts_q, stat_mispredicts_d;
  always_comb begin
    stat_branches_d    = stat_branches_q + 32'(update_valid);
    stat_mispredicts_d = stat_mispredicts_q + 32'(mispredict);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic 2-bit saturating-counter branch history table (BHT) in the fetch stage.
- Produces the per-instruction prediction bit that travels through IF/ID into the ID/EX register's prediction field.
- Accepts resolution updates from the execute stage and flags mispredictions so the pipeline can flush.
- Sits directly upstream of the ID/EX register; it is the source of that register's prediction input.

Parameters:
- INDEX_BITS, 6, log2 of BHT entries (64 entries).
- PC_WIDTH, 64, program counter width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- fetch_pc  in  PC_WIDTH  PC of the instruction being fetched.
- fetch_branch  in  1  fetched instruction is a conditional branch (from predecode).
- prediction  out  1  predicted taken; combinational from fetch_pc; 0 when fetch_branch=0.
- update_valid  in  1  EX stage resolved a conditional branch this cycle.
- update_pc  in  PC_WIDTH  PC of the resolved branch.
- update_taken  in  1  actual outcome.
- update_prediction  in  1  prediction carried down the pipeline with that branch.
- mispredict  out  1  combinational: update_valid & (update_taken != update_prediction).

Behaviour:
- Index: idx = pc[INDEX_BITS+1:2] for both lookup and update; upper PC bits are ignored (aliasing is permitted).
- Counter encoding:
  - 00 = strong not-taken (SNT), 01 = weak not-taken (WNT), 10 = weak taken (WT), 11 = strong taken (ST).
  - Predict taken = counter MSB.
- Update: on rising clk with update_valid=1, counter[idx(update_pc)] changes as follows.
  - update_taken=1: +1, saturating at 11.
  - update_taken=0: -1, saturating at 00.
- update_valid=0: no table change.
- Lookup latency is 0 cycles (combinational read of current table state). An update becomes visible to lookups on the cycle after its clock edge.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update value (no bypass).
- The update path does not depend on update_prediction. That input only drives mispredict.
- Flushing the IF/ID and ID/EX registers on mispredict is done outside this block. This block holds no pending state, so a flush needs no internal action.
- Reset:
  - Asynchronous assertion sets every counter to 01 (WNT).
  - prediction then reads 0 for any branch.
  - mispredict follows its inputs combinationally regardless of reset.
- Reset asserted mid-update: the reset wins and the update is lost.
- Reset is released synchronously by the external reset synchroniser; the table is usable from the first clk edge after release.

Optional Feature:
- Macro: BP_STATS_EN.
- When defined, the block adds two outputs:
  - stat_branches (32-bit): count of update_valid cycles.
  - stat_mispredicts (32-bit): count of mispredict cycles.
- Both counters:
  - clear to 0 on reset;
  - increment on rising clk;
  - wrap from 0xFFFFFFFF to 0;
  - both increment in the same cycle when a mispredicting update occurs.
- When not defined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Package bp_pkg holds:
  - the 2-bit counter type;
  - constants CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11;
  - pure function ctr_next(ctr, taken) implementing the saturating update.
- One sub-module is natural: bp_counter_table.
  - Contents: the 2^INDEX_BITS x 2-bit storage array.
  - Ports: one asynchronous read port, one synchronous write port, async active-low reset.
- Top level keeps index extraction, the mispredict compare and the optional stats counters.

Test Plan:
- Reset: pulse reset low, then fetch_pc=0x100 with fetch_branch=1 -> prediction=0. Repeat at fetch_pc=0x1FC -> prediction=0.
- Training: update pc=0x100 taken=1 twice. Next cycle fetch 0x100 -> prediction=1 (counter 11). Three not-taken updates -> counter 00, prediction=0. A fourth not-taken update -> counter stays 00.
- Mispredict flag: update_valid=1, taken=1, update_prediction=0 -> mispredict=1 in the same cycle. taken=1, update_prediction=1 -> mispredict=0. update_valid=0 -> mispredict=0.
- Same-cycle hazard: counter at 01, update 0x100 taken=1 while fetching 0x100 -> prediction=0 that cycle, 1 the following cycle.
- Aliasing and gating:
  - Train 0x100 to 11 -> fetch 0x200 (same index with INDEX_BITS=6) predicts 1.
  - fetch_branch=0 at 0x100 -> prediction=0.
  - Async reset pulsed mid-cycle -> all entries return to 01 immediately.
- BP_STATS_EN: 5 updates, 2 of them mispredicting -> stat_branches=5, stat_mispredicts=2. Preload near wrap -> 0xFFFFFFFF+1 wraps to 0.
